// File: rtl/qpsk_carrier_gen.sv
// QPSK carrier generator: phase accumulator into a quarter-wave sine ROM, giving a reference
// carrier plus a carrier phase-shifted by Gray-mapped symbols that switch only on period boundaries.
module qpsk_carrier_gen #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int AMP     = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               sym_valid,
    input  logic [1:0]         sym,
    output logic               sym_ready,
    output logic [DATA_W-1:0]  car_out,
    output logic [DATA_W-1:0]  mod_out,
    output logic               out_valid,
    output logic               sym_strobe,
    output logic               underrun
);

    localparam int IDX_W   = ADDR_W - 2;
    localparam int QUARTER = 1 << IDX_W;
    localparam int ROM_N   = QUARTER + 1;
    localparam logic [IDX_W:0] QUARTER_IDX = (IDX_W + 1)'(QUARTER);
    localparam real PI = 3.14159265358979323846;

    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        real x;
        x = real'(AMP) * $sin(2.0 * PI * real'(k) / real'(1 << ADDR_W));
        return DATA_W'($rtoi(x + 0.5));
    endfunction

    logic [DATA_W-1:0] rom [ROM_N];

    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        assign rom[k] = sine_entry(k);
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   sum;
    logic               wrap;
    logic               accept;
    logic [1:0]         active;
    logic [1:0]         pend_sym;
    logic               pend_valid;
    logic               bnd_flag;
    logic               bnd_strobe;
    logic [1:0]         gray_idx;
    logic [PHASE_W-1:0] sym_off;
    logic [PHASE_W-1:0] mod_phase;

    assign sum       = {1'b0, acc} + {1'b0, ftw};
    assign wrap      = en & sum[PHASE_W];
    assign sym_ready = ~pend_valid | wrap;
    assign accept    = sym_valid & sym_ready;

    // Gray dibit to phase slot m, offset = (2m+1) eighths of a turn
    assign gray_idx  = {active[1], active[1] ^ active[0]};
    assign sym_off   = PHASE_W'({gray_idx, 1'b1}) << (PHASE_W - 3);
    assign mod_phase = acc + sym_off;

    // A wrap marks the next enabled sample as a boundary; the flag survives En gaps until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            active     <= 2'b00;
            pend_sym   <= 2'b00;
            pend_valid <= 1'b0;
            bnd_flag   <= 1'b0;
            bnd_strobe <= 1'b0;
        end else begin
            if (en) begin
                acc      <= sum[PHASE_W-1:0];
                bnd_flag <= wrap;
            end
            if (accept) begin
                pend_sym <= sym;
            end
            if (wrap) begin
                if (pend_valid) begin
                    active     <= pend_sym;
                    bnd_strobe <= 1'b1;
                    pend_valid <= accept;
                end else if (accept) begin
                    active     <= sym;
                    bnd_strobe <= 1'b1;
                end else begin
                    bnd_strobe <= 1'b0;
                end
            end else if (accept) begin
                pend_valid <= 1'b1;
            end
        end
    end

    logic             s1_valid;
    logic             s1_strobe;
    logic             s1_under;
    logic [1:0]       s1_car_q;
    logic [1:0]       s1_mod_q;
    logic [IDX_W-1:0] s1_car_i;
    logic [IDX_W-1:0] s1_mod_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_strobe <= 1'b0;
            s1_under  <= 1'b0;
            s1_car_q  <= '0;
            s1_mod_q  <= '0;
            s1_car_i  <= '0;
            s1_mod_i  <= '0;
        end else begin
            s1_valid  <= en;
            s1_strobe <= en & bnd_flag & bnd_strobe;
            s1_under  <= en & bnd_flag & ~bnd_strobe;
            if (en) begin
                s1_car_q <= acc[PHASE_W-1 -: 2];
                s1_car_i <= acc[PHASE_W-3 -: IDX_W];
                s1_mod_q <= mod_phase[PHASE_W-1 -: 2];
                s1_mod_i <= mod_phase[PHASE_W-3 -: IDX_W];
            end
        end
    end

    logic [IDX_W:0]    car_ridx;
    logic [IDX_W:0]    mod_ridx;
    logic [DATA_W-1:0] car_mag;
    logic [DATA_W-1:0] mod_mag;
    logic [DATA_W-1:0] car_val;
    logic [DATA_W-1:0] mod_val;

    // Odd quadrants read the ROM backwards; index 0 there lands on the extra peak entry.
    always_comb begin
        car_ridx = s1_car_q[0] ? QUARTER_IDX - {1'b0, s1_car_i} : {1'b0, s1_car_i};
        mod_ridx = s1_mod_q[0] ? QUARTER_IDX - {1'b0, s1_mod_i} : {1'b0, s1_mod_i};
        car_mag  = rom[car_ridx];
        mod_mag  = rom[mod_ridx];
        car_val  = s1_car_q[1] ? -car_mag : car_mag;
        mod_val  = s1_mod_q[1] ? -mod_mag : mod_mag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            car_out    <= '0;
            mod_out    <= '0;
        end else begin
            out_valid  <= s1_valid;
            sym_strobe <= s1_strobe;
            underrun   <= s1_under;
            if (s1_valid) begin
                car_out <= car_val;
                mod_out <= mod_val;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_carrier_gen.sv
// Bench for qpsk_carrier_gen: real-valued sine/phase model compared every cycle, plus
// directed scenarios with literal expectations taken from hand-computed waveforms.
module tb_qpsk_carrier_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] ftw = 16'h1000;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym = 2'b00;
    logic        sym_ready;
    logic [7:0]  car_out;
    logic [7:0]  mod_out;
    logic        out_valid;
    logic        sym_strobe;
    logic        underrun;

    int pass_cnt = 0;
    int total_cnt = 0;

    qpsk_carrier_gen #(.DATA_W(8), .PHASE_W(16), .ADDR_W(8), .AMP(127)) dut (
        .clk(clk), .rst(rst), .en(en), .ftw(ftw), .sym_valid(sym_valid), .sym(sym),
        .sym_ready(sym_ready), .car_out(car_out), .mod_out(mod_out),
        .out_valid(out_valid), .sym_strobe(sym_strobe), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    function automatic int model_sine(input int phase);
        real v;
        int a;
        a = (phase >> 8) & 255;
        v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    function automatic int phase_off(input int s);
        int deg;
        case (s)
            0: deg = 45;
            1: deg = 135;
            3: deg = 225;
            default: deg = 315;
        endcase
        return deg * 65536 / 360;
    endfunction

    // Model state: mathematical phase, symbol registers, and the two-sample output delay
    int m_acc, m_active, m_pend_sym, m1_car, m1_mod, m_car, m_mod;
    bit m_pend, m_bnd, m_bnd_st, m1_v, m1_st, m1_un, m2_v, m2_st, m2_un, m_wrap, m_take;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_acc = 0; m_active = 0; m_pend_sym = 0; m_pend = 0; m_bnd = 0; m_bnd_st = 0;
            m1_v = 0; m1_st = 0; m1_un = 0; m1_car = 0; m1_mod = 0;
            m2_v = 0; m2_st = 0; m2_un = 0; m_car = 0; m_mod = 0;
        end else begin
            m2_v = m1_v; m2_st = m1_st; m2_un = m1_un;
            if (m1_v) begin m_car = m1_car; m_mod = m1_mod; end
            m_wrap = en && (m_acc + int'(ftw) >= 65536);
            m_take = sym_valid && (!m_pend || m_wrap);
            m1_v  = en;
            m1_st = en && m_bnd && m_bnd_st;
            m1_un = en && m_bnd && !m_bnd_st;
            if (en) begin
                m1_car = model_sine(m_acc);
                m1_mod = model_sine((m_acc + phase_off(m_active)) % 65536);
                m_bnd  = 0;
            end
            if (m_wrap) begin
                m_bnd = 1;
                if (m_pend) begin
                    m_active = m_pend_sym; m_bnd_st = 1; m_pend = m_take;
                    if (m_take) m_pend_sym = int'(sym);
                end else if (m_take) begin
                    m_active = int'(sym); m_bnd_st = 1;
                end else begin
                    m_bnd_st = 0;
                end
            end else if (m_take) begin
                m_pend = 1; m_pend_sym = int'(sym);
            end
            if (en) m_acc = (m_acc + int'(ftw)) % 65536;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check_output("out_valid", int'(out_valid), int'(m2_v));
            check_output("sym_strobe", int'(sym_strobe), int'(m2_v && m2_st));
            check_output("underrun", int'(underrun), int'(m2_v && m2_un));
            check_output("car_out", int'($signed(car_out)), m_car);
            check_output("mod_out", int'($signed(mod_out)), m_mod);
            check_output("sym_ready", int'(sym_ready),
                         int'(!m_pend || (en && (m_acc + int'(ftw) >= 65536))));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1; en = 1'b0; sym_valid = 1'b0; sym = 2'b00; ftw = 16'h1000;
        step();
        step();
    endtask

    int car_seq [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};
    int bnd_mod [4] = '{90, 90, -90, -90};
    logic [1:0] stream_syms [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    initial begin
        int idx;
        bit took;

        // Reset state
        reset_dut();
        check_output("rst_car", int'(car_out), 0);
        check_output("rst_mod", int'(mod_out), 0);
        check_output("rst_valid", int'(out_valid), 0);
        check_output("rst_strobe", int'(sym_strobe), 0);
        check_output("rst_underrun", int'(underrun), 0);
        check_output("rst_ready", int'(sym_ready), 1);

        // Free-running carrier, no symbols
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1) check_output("latency_v1", int'(out_valid), 0);
            if (k == 2) check_output("first_mod", int'($signed(mod_out)), 90);
            if (k >= 2 && k <= 17) check_output("car_seq", int'($signed(car_out)), car_seq[k-2]);
            if (k == 18) begin
                check_output("first_underrun", int'(underrun), 1);
                check_output("first_bnd_car", int'($signed(car_out)), 0);
            end
        end

        // Symbol 01 pending before the first wrap
        reset_dut();
        rst = 1'b0; en = 1'b1; sym_valid = 1'b1; sym = 2'b01;
        for (int k = 1; k <= 18; k++) begin
            step();
            sym_valid = 1'b0;
            if (k == 1) check_output("pend_ready", int'(sym_ready), 0);
            if (k == 14) check_output("pend_ready14", int'(sym_ready), 0);
            if (k == 15) check_output("wrap_ready", int'(sym_ready), 1);
            if (k == 18) begin
                check_output("pend_strobe", int'(sym_strobe), 1);
                check_output("pend_underrun", int'(underrun), 0);
                check_output("pend_mod", int'($signed(mod_out)), 90);
            end
        end

        // Stream 00,01,11,10 with valid held high
        reset_dut();
        rst = 1'b0; en = 1'b1;
        idx = 0; sym = stream_syms[0]; sym_valid = 1'b1; took = sym_ready;
        for (int k = 1; k <= 70; k++) begin
            step();
            check_output("stream_underrun", int'(underrun), 0);
            if (k == 18 || k == 34 || k == 50 || k == 66) begin
                check_output("stream_strobe", int'(sym_strobe), 1);
                check_output("stream_mod", int'($signed(mod_out)), bnd_mod[(k - 18) / 16]);
            end
            if (took) idx++;
            sym_valid = (idx < 4);
            if (idx < 4) sym = stream_syms[idx];
            took = sym_valid && sym_ready;
        end
        check_output("stream_count", idx, 4);

        // Bypass: symbol offered only in the wrap cycle
        reset_dut();
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            step();
            sym_valid = 1'b0;
            if (k == 15) begin
                check_output("bypass_ready", int'(sym_ready), 1);
                sym_valid = 1'b1; sym = 2'b11;
            end
            if (k == 18) begin
                check_output("bypass_strobe", int'(sym_strobe), 1);
                check_output("bypass_underrun", int'(underrun), 0);
                check_output("bypass_mod", int'($signed(mod_out)), -90);
            end
            if (k == 34) check_output("bypass_next_underrun", int'(underrun), 1);
        end

        // En gap of three cycles
        reset_dut();
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            en = !(k >= 5 && k <= 7);
            if (k == 8) begin
                check_output("gap_valid8", int'(out_valid), 0);
                check_output("gap_hold_car", int'($signed(car_out)), 127);
            end
            if (k == 9) check_output("gap_valid9", int'(out_valid), 0);
            if (k == 10) check_output("gap_resume_car", int'($signed(car_out)), 117);
            if (k == 11) check_output("gap_next_car", int'($signed(car_out)), 90);
        end

        // Reset mid-period with a symbol pending
        reset_dut();
        rst = 1'b0; en = 1'b1; sym_valid = 1'b1; sym = 2'b10;
        for (int k = 1; k <= 6; k++) begin
            step();
            sym_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_output("midrst_car", int'(car_out), 0);
        check_output("midrst_mod", int'(mod_out), 0);
        check_output("midrst_valid", int'(out_valid), 0);
        check_output("midrst_ready", int'(sym_ready), 1);
        en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 2) check_output("restart_mod", int'($signed(mod_out)), 90);
            if (k == 18) begin
                check_output("restart_underrun", int'(underrun), 1);
                check_output("restart_strobe", int'(sym_strobe), 0);
                check_output("restart_mod16", int'($signed(mod_out)), 90);
            end
        end

        en = 1'b0;
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/qpsk_carrier_gen.md
# qpsk_carrier_gen

Parametrised QPSK carrier generator. A phase accumulator is driven by a programmable frequency tuning word and addresses a quarter-wave sine ROM, producing an unmodulated reference carrier and a QPSK-modulated carrier. The modulated carrier is phase-shifted by Gray-mapped 2-bit symbols, which are accepted through a valid/ready handshake and applied only on carrier-period boundaries. It replaces the fixed 30-entry sine table and sits between the symbol source and the DAC/output stage of the QPSK transmit path.

## Interface
Parameters:
- DATA_W, 8: signed output sample width.
- PHASE_W, 16: phase accumulator and tuning-word width.
- ADDR_W, 8: phase bits used for lookup (full-wave resolution 2^ADDR_W points). Must satisfy ADDR_W ≥ 3 and ADDR_W ≤ PHASE_W.
- AMP, 127: peak amplitude. Must satisfy AMP ≤ 2^(DATA_W-1)-1.

Ports:
- Clk, in, 1: clock; all state changes on the rising edge.
- Rst, in, 1: asynchronous, active-high reset.
- En, in, 1: advance enable; one sample per cycle while high.
- Ftw, in, PHASE_W: unsigned phase increment per enabled cycle.
- Sym_valid, in, 1: Sym holds a symbol.
- Sym, in, 2: QPSK dibit.
- Sym_ready, out, 1: the symbol buffer can accept a symbol this cycle.
- Car_out, out, DATA_W: signed sample AMP·sin(θ).
- Mod_out, out, DATA_W: signed sample AMP·sin(θ+φ).
- Out_valid, out, 1: Car_out and Mod_out hold a new sample.
- Sym_strobe, out, 1: a new symbol took effect at this boundary; aligned with the sample it affects.
- Underrun, out, 1: a boundary occurred with no symbol available; aligned with that sample.

## Operation
- Phase accumulator: acc ← acc + Ftw, modulo 2^PHASE_W, on each cycle with En=1. Sample n uses θ = acc before that add.
- Wrap condition: the add carries out of bit PHASE_W-1 while En=1. The sample that uses the post-wrap phase is the first sample of a new carrier period (the "boundary sample").
- Symbol phase φ, Gray-mapped:
  - 00 → 45°
  - 01 → 135°
  - 11 → 225°
  - 10 → 315°
  - Encoded as offset = (2m+1)·2^(PHASE_W-3), where m = 0,1,2,3 in the order above.
  - The offset is added modulo 2^PHASE_W.
- Lookup address: the top ADDR_W bits of the phase.
  - Quadrant = top 2 bits of the address. Index = remaining ADDR_W-2 bits, mirrored in quadrants 1 and 3.
  - Result is negated in quadrants 2 and 3.
  - The quadrant-1 mirror of index 0 reads ROM entry 2^(ADDR_W-2), so the ROM holds 2^(ADDR_W-2)+1 entries.
  - Entry k = round(AMP·sin(2πk/2^ADDR_W)), computed at elaboration.
  - Two independent reads per sample: one for Car_out, one for Mod_out.
- Symbol buffer: one pending register.
  - Sym_ready = !pend_valid | (En & wrap).
  - A symbol is accepted when Sym_valid & Sym_ready.
- At each wrap:
  - If pending is full: active ← pending, pending empties (or refills if a new symbol is accepted in the same cycle), Sym_strobe on the boundary sample.
  - If pending is empty and a symbol is accepted in the same cycle: bypass, active ← Sym, Sym_strobe asserted, no Underrun.
  - If no symbol is available: active unchanged, Underrun on the boundary sample.
- En=0: acc, active symbol and pending hold; the handshake still accepts into an empty pending register.
- Ftw=0: no wraps; output is constant; the symbol is never updated.
- Reset values: acc=0, active=00, pending empty, Sym_ready=1, Car_out=0, Mod_out=0, Out_valid=0, Sym_strobe=0, Underrun=0. Pipeline contents are discarded.

## Timing
- Latency is 2 cycles from an En=1 cycle to its sample on the outputs with Out_valid=1.
  - Stage 1 registers quadrant and index.
  - Stage 2 registers the ROM outputs with negation applied.
- Out_valid, Sym_strobe and Underrun are delayed by exactly the same 2 stages. All are 1-cycle pulses per sample.
- Outputs hold their last value while Out_valid=0.
- A change to Ftw affects the next accumulator add.
- Sym_ready is combinational from pend_valid, En and the wrap condition. There is no combinational path from Sym_valid to Sym_ready.
- Reset asserted mid-operation clears everything immediately. The first valid sample comes 2 cycles after the first En=1 following reset release.

## Test plan
- Reset, Ftw=0x1000, En=1 continuously, no symbols:
  - First Out_valid 2 cycles after En.
  - Car_out sequence over 16 samples: 0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49.
  - Mod_out starts at 90 (the Car_out sequence shifted by 45°).
  - Underrun at sample 16.
- Sym=01 presented before the first wrap → pending accepted, Sym_ready=0; at sample 16 Sym_strobe=1, Mod_out=90 (θ=0, φ=135°); Sym_ready returns to 1 in the wrap cycle.
- Symbols 00, 01, 11, 10 streamed with Sym_valid held high:
  - One symbol accepted per carrier period.
  - Boundary Mod_out = 90, 90, -90, -90; with θ=0 the expected values are 90, 90, -90, -90.
  - Sym_strobe each period; Underrun never asserts.
- Pending empty, Sym_valid asserted exactly in the wrap cycle → bypass, symbol applied at that boundary sample, Sym_strobe=1, Underrun=0.
- En toggled 1-0-1 → acc holds while En=0; Out_valid gaps match the En gaps shifted by 2 cycles; no sample duplicated or skipped.
- Rst pulsed mid-period with a symbol pending → all outputs 0 and Sym_ready=1 immediately; after restart the pending symbol is lost and active=00.
